// File: rtl/sys_array_ctrl.sv
// sys_array_ctrl: job sequencer for a weight-stationary systolic array.
// Latches the weight matrix, skews input vectors into the array and deskews per-row results.
module sys_array_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W_W  = 4,
  parameter int ARRAY_W_L  = 4,
  parameter int LAT_BASE   = 5,
  parameter int CNT_W      = 16
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        start,
  input  logic [CNT_W-1:0]                            num_vec,
  input  logic [ARRAY_W_W*ARRAY_W_L*DATA_WIDTH-1:0]   weight_in,
  output logic                                        busy,
  output logic                                        done,
  input  logic                                        in_valid,
  input  logic [ARRAY_W_L*DATA_WIDTH-1:0]             in_data,
  output logic                                        in_ready,
  output logic                                        arr_weights_load,
  output logic [ARRAY_W_W*ARRAY_W_L*DATA_WIDTH-1:0]   arr_weight_data,
  output logic [ARRAY_W_L*DATA_WIDTH-1:0]             arr_input_data,
  input  logic [ARRAY_W_W*2*DATA_WIDTH-1:0]           arr_output_data,
  output logic                                        out_valid,
  output logic [ARRAY_W_W*2*DATA_WIDTH-1:0]           out_data
);

  localparam int OUT_W      = 2 * DATA_WIDTH;
  localparam int WMAT_W     = ARRAY_W_W * ARRAY_W_L * DATA_WIDTH;
  // A vector accepted at cycle c leaves the deskew network at c + PIPE_DEPTH.
  localparam int PIPE_DEPTH = LAT_BASE + ARRAY_W_W;
  localparam int DRAIN_W    = $clog2(PIPE_DEPTH + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD_W = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  logic [1:0]                   state_q,  state_d;
  logic [WMAT_W-1:0]            weight_q, weight_d;
  logic [CNT_W-1:0]             remain_q, remain_d;
  logic [DRAIN_W-1:0]           drain_q,  drain_d;
  logic [PIPE_DEPTH-1:0]        tag_q;
  logic [ARRAY_W_W*OUT_W-1:0]   aligned;
  logic                         accept;

  assign accept           = (state_q == ST_STREAM) && in_valid;
  assign in_ready         = (state_q == ST_STREAM);
  assign arr_weights_load = (state_q == ST_LOAD_W);
  assign done             = (state_q == ST_DRAIN) && (drain_q == '0);
  assign busy             = (state_q != ST_IDLE) && !done;
  assign arr_weight_data  = weight_q;

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_d  = state_q;
    weight_d = weight_q;
    remain_d = remain_q;
    drain_d  = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          weight_d = weight_in;
          remain_d = num_vec;
          state_d  = ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (remain_q == '0) begin
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (accept) begin
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            drain_d = DRAIN_W'(PIPE_DEPTH);
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      weight_q <= '0;
      remain_q <= '0;
      drain_q  <= '0;
      tag_q    <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q  <= state_d;
      weight_q <= weight_d;
      remain_q <= remain_d;
      drain_q  <= drain_d;
      tag_q    <= {tag_q[PIPE_DEPTH-2:0], accept};
    end
  end

  assign out_valid = tag_q[PIPE_DEPTH-1];

  // Column j is delayed j+1 cycles; bubbles and idle cycles inject zeros.
  for (genvar j = 0; j < ARRAY_W_L; j++) begin : g_skew
    logic [DATA_WIDTH-1:0] chain_q [j+1];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        // NOTE: this storage is reset on purpose so an aborted job leaves nothing in flight.
        for (int k = 0; k <= j; k++) chain_q[k] <= '0;
      end else begin
        chain_q[0] <= accept ? in_data[j*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= j; k++) chain_q[k] <= chain_q[k-1];
      end
    end

    assign arr_input_data[j*DATA_WIDTH +: DATA_WIDTH] = chain_q[j];
  end

  // Row i arrives i cycles after row 0, so it waits W_W-1-i cycles to line up with the last row.
  for (genvar i = 0; i < ARRAY_W_W; i++) begin : g_deskew
    localparam int DEPTH = ARRAY_W_W - 1 - i;

    if (DEPTH == 0) begin : g_pass
      assign aligned[i*OUT_W +: OUT_W] = arr_output_data[i*OUT_W +: OUT_W];
    end else begin : g_dly
      logic [OUT_W-1:0] dly_q [DEPTH];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < DEPTH; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= arr_output_data[i*OUT_W +: OUT_W];
          for (int k = 1; k < DEPTH; k++) dly_q[k] <= dly_q[k-1];
        end
      end

      assign aligned[i*OUT_W +: OUT_W] = dly_q[DEPTH-1];
    end
  end

  // Gating keeps out_data at zero whenever no result is being presented.
  assign out_data = out_valid ? aligned : '0;

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Self-checking bench for sys_array_ctrl: behavioural array model plus result scoreboard.
`timescale 1ns/1ps
module tb_sys_array_ctrl;

  localparam int DW   = 8;
  localparam int WW   = 4;
  localparam int WL   = 4;
  localparam int LAT  = 5;
  localparam int CW   = 16;
  localparam int OW   = 2 * DW;
  localparam int PIPE = LAT + WW;

  typedef logic [WL*DW-1:0]    vec_t;
  typedef logic [WW*WL*DW-1:0] wmat_t;
  typedef logic [WW*OW-1:0]    res_t;
  typedef struct { res_t data; int cyc; } exp_t;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [CW-1:0] num_vec;
  wmat_t         weight_in;
  logic          busy;
  logic          done;
  logic          in_valid;
  vec_t          in_data;
  logic          in_ready;
  logic          arr_weights_load;
  wmat_t         arr_weight_data;
  vec_t          arr_input_data;
  res_t          arr_output_data;
  logic          out_valid;
  res_t          out_data;

  sys_array_ctrl #(
    .DATA_WIDTH(DW), .ARRAY_W_W(WW), .ARRAY_W_L(WL), .LAT_BASE(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_vec(num_vec),
    .weight_in(weight_in), .busy(busy), .done(done), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .arr_weights_load(arr_weights_load),
    .arr_weight_data(arr_weight_data), .arr_input_data(arr_input_data),
    .arr_output_data(arr_output_data), .out_valid(out_valid), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    last_acc_cyc = 0;
  int    start_cyc = 0;
  int    wl_cnt = 0;
  int    ov_cnt = 0;
  wmat_t exp_w = '0;
  wmat_t arr_w = '0;
  vec_t  hist [16];
  exp_t  sb_q [$];

  function automatic res_t compute(input wmat_t w, input vec_t x);
    res_t r = '0;
    for (int i = 0; i < WW; i++)
      for (int j = 0; j < WL; j++)
        r[i*OW +: OW] = r[i*OW +: OW] + OW'(w[(i*WL+j)*DW +: DW]) * OW'(x[j*DW +: DW]);
    return r;
  endfunction

  // Systolic array model: row i at cycle T sees x[j] that was on input column j at T-LAT-i+j.
  function automatic res_t array_out(input int t_now);
    res_t r = '0;
    for (int i = 0; i < WW; i++) begin
      int t0 = t_now - LAT - i;
      if (t0 >= 0)
        for (int j = 0; j < WL; j++)
          r[i*OW +: OW] = r[i*OW +: OW]
                        + OW'(arr_w[(i*WL+j)*DW +: DW]) * OW'(hist[(t0+j)%16][j*DW +: DW]);
    end
    return r;
  endfunction

  function automatic wmat_t mk_fill(input int v);
    wmat_t w;
    for (int k = 0; k < WW*WL; k++) w[k*DW +: DW] = DW'(v);
    return w;
  endfunction

  function automatic wmat_t mk_identity();
    wmat_t w = '0;
    for (int i = 0; i < WW; i++) w[(i*WL+i)*DW +: DW] = DW'(1);
    return w;
  endfunction

  function automatic wmat_t mk_ramp();
    wmat_t w;
    for (int k = 0; k < WW*WL; k++) w[k*DW +: DW] = DW'(k + 1);
    return w;
  endfunction

  function automatic vec_t mk_vec(input int a, input int b, input int c, input int d);
    vec_t x;
    x[0*DW +: DW] = DW'(a);
    x[1*DW +: DW] = DW'(b);
    x[2*DW +: DW] = DW'(c);
    x[3*DW +: DW] = DW'(d);
    return x;
  endfunction

  initial begin
    for (int k = 0; k < 16; k++) hist[k] = '0;
    arr_output_data = '0;
  end

  // Array model, weight-load counter and scoreboard push on acceptance.
  always @(posedge clk) begin
    hist[cyc%16] = arr_input_data;
    if (arr_weights_load) begin
      arr_w = arr_weight_data;
      wl_cnt++;
    end
    if (in_valid && in_ready) begin
      sb_q.push_back('{compute(exp_w, in_data), cyc + PIPE});
      last_acc_cyc = cyc;
    end
    cyc++;
    #1;
    arr_output_data = array_out(cyc);
  end

  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      ov_cnt++;
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out_valid: cycle %0d out_data=%h, nothing expected", cyc, out_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (out_data !== e.data || cyc !== e.cyc) begin
          n_err++;
          $display("FAIL result: got %h at cycle %0d, want %h at cycle %0d", out_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic start_job(input wmat_t w, input logic [CW-1:0] n);
    start     = 1'b1;
    weight_in = w;
    num_vec   = n;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_vec(input vec_t x);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout: in_ready=%b after 50 cycles, want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done(output int dcyc, output logic busy_at_done);
    dcyc = -1;
    busy_at_done = 1'bx;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        dcyc = cyc;
        busy_at_done = busy;
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, in_ready, arr_weights_load, out_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b, want 00000", {busy, done, in_ready, arr_weights_load, out_valid});
    end
    n_vec++;
    if (arr_weight_data !== '0) begin
      n_err++;
      $display("FAIL reset_weights: got %h, want 0", arr_weight_data);
    end
    n_vec++;
    if (arr_input_data !== '0) begin
      n_err++;
      $display("FAIL reset_skew: got %h, want 0", arr_input_data);
    end
    n_vec++;
    if (out_data !== '0) begin
      n_err++;
      $display("FAIL reset_out_data: got %h, want 0", out_data);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_stream();
    int dones = 0;
    @(negedge clk);
    exp_w = mk_fill(3);
    start_job(exp_w, 16'd3);
    send_vec(mk_vec(5, 6, 7, 8));
    n_vec++;
    if ({busy, in_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL mid_stream_state: busy,in_ready=%b, want 11", {busy, in_ready});
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, in_ready, arr_weights_load, out_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL abort_ctrl: got %b, want 00000", {busy, done, in_ready, arr_weights_load, out_valid});
    end
    n_vec++;
    if (arr_input_data !== '0) begin
      n_err++;
      $display("FAIL abort_skew: got %h, want 0", arr_input_data);
    end
    sb_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_vec++;
    if (dones !== 0) begin
      n_err++;
      $display("FAIL abort_no_done: got %0d done pulses, want 0", dones);
    end
  endtask

  task automatic test_identity();
    int c, d, ov0;
    logic b;
    @(negedge clk);
    wl_cnt = 0;
    ov0 = ov_cnt;
    exp_w = mk_identity();
    start_job(exp_w, 16'd1);
    send_vec(mk_vec(1, 2, 3, 4));
    c = last_acc_cyc;
    wait_done(d, b);
    n_vec++;
    if (d !== c + 10) begin
      n_err++;
      $display("FAIL identity_done_cycle: got %0d, want %0d", d, c + 10);
    end
    n_vec++;
    if (b !== 1'b0) begin
      n_err++;
      $display("FAIL identity_busy_at_done: got %b, want 0", b);
    end
    n_vec++;
    if (wl_cnt !== 1) begin
      n_err++;
      $display("FAIL identity_load_pulse: got %0d cycles, want 1", wl_cnt);
    end
    n_vec++;
    if (ov_cnt - ov0 !== 1) begin
      n_err++;
      $display("FAIL identity_out_count: got %0d, want 1", ov_cnt - ov0);
    end
  endtask

  task automatic test_back_to_back();
    int a, d, ov0;
    logic b;
    @(negedge clk);
    ov0 = ov_cnt;
    exp_w = mk_fill(2);
    start_job(exp_w, 16'd3);
    in_valid = 1'b1;
    in_data  = mk_vec(1, 1, 1, 1);
    send_vec(mk_vec(1, 1, 1, 1));
    a = last_acc_cyc;
    send_vec(mk_vec(2, 2, 2, 2));
    send_vec(mk_vec(255, 255, 255, 255));
    n_vec++;
    if (last_acc_cyc !== a + 2) begin
      n_err++;
      $display("FAIL b2b_accept: last accepted at %0d, want %0d", last_acc_cyc, a + 2);
    end
    wait_done(d, b);
    n_vec++;
    if (d !== last_acc_cyc + 10) begin
      n_err++;
      $display("FAIL b2b_done_cycle: got %0d, want %0d", d, last_acc_cyc + 10);
    end
    n_vec++;
    if (ov_cnt - ov0 !== 3) begin
      n_err++;
      $display("FAIL b2b_out_count: got %0d, want 3", ov_cnt - ov0);
    end
  endtask

  task automatic test_bubbles();
    int a, d, ov0;
    logic b;
    @(negedge clk);
    ov0 = ov_cnt;
    exp_w = mk_ramp();
    start_job(exp_w, 16'd2);
    send_vec(mk_vec(9, 20, 33, 47));
    a = last_acc_cyc;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bubble_in_ready: got %b during bubble, want 1", in_ready);
    end
    repeat (2) @(negedge clk);
    send_vec(mk_vec(200, 3, 128, 77));
    n_vec++;
    if (last_acc_cyc !== a + 3) begin
      n_err++;
      $display("FAIL bubble_accept: second accepted at %0d, want %0d", last_acc_cyc, a + 3);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bubble_ready_drop: got %b after last acceptance, want 0", in_ready);
    end
    wait_done(d, b);
    n_vec++;
    if (d !== last_acc_cyc + 10) begin
      n_err++;
      $display("FAIL bubble_done_cycle: got %0d, want %0d", d, last_acc_cyc + 10);
    end
    n_vec++;
    if (ov_cnt - ov0 !== 2) begin
      n_err++;
      $display("FAIL bubble_out_count: got %0d, want 2", ov_cnt - ov0);
    end
  endtask

  task automatic test_zero();
    int d, ov0;
    logic b;
    @(negedge clk);
    ov0 = ov_cnt;
    wl_cnt = 0;
    exp_w = mk_fill(9);
    start_job(exp_w, 16'd0);
    n_vec++;
    if ({arr_weights_load, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL zero_load: weights_load,busy=%b, want 11", {arr_weights_load, busy});
    end
    wait_done(d, b);
    n_vec++;
    if (d !== start_cyc + 2) begin
      n_err++;
      $display("FAIL zero_done_cycle: got %0d, want %0d", d, start_cyc + 2);
    end
    n_vec++;
    if (b !== 1'b0) begin
      n_err++;
      $display("FAIL zero_busy_at_done: got %b, want 0", b);
    end
    repeat (12) @(negedge clk);
    n_vec++;
    if (wl_cnt !== 1) begin
      n_err++;
      $display("FAIL zero_load_pulse: got %0d cycles, want 1", wl_cnt);
    end
    n_vec++;
    if (ov_cnt - ov0 !== 0) begin
      n_err++;
      $display("FAIL zero_out_count: got %0d, want 0", ov_cnt - ov0);
    end
  endtask

  task automatic test_start_ignored();
    int d, ov0;
    logic b;
    wmat_t wa;
    @(negedge clk);
    ov0 = ov_cnt;
    wa = mk_ramp();
    exp_w = wa;
    start_job(wa, 16'd2);
    send_vec(mk_vec(10, 11, 12, 13));
    start     = 1'b1;
    weight_in = mk_fill(7);
    num_vec   = 16'd5;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (arr_weight_data !== wa) begin
      n_err++;
      $display("FAIL ignore_weights: got %h, want %h", arr_weight_data, wa);
    end
    n_vec++;
    if ({busy, in_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL ignore_state: busy,in_ready=%b, want 11", {busy, in_ready});
    end
    send_vec(mk_vec(250, 1, 99, 4));
    wait_done(d, b);
    n_vec++;
    if (d !== last_acc_cyc + 10) begin
      n_err++;
      $display("FAIL ignore_done_cycle: got %0d, want %0d", d, last_acc_cyc + 10);
    end
    n_vec++;
    if (ov_cnt - ov0 !== 2) begin
      n_err++;
      $display("FAIL ignore_out_count: got %0d, want 2", ov_cnt - ov0);
    end
    @(negedge clk);
    n_vec++;
    if (arr_weight_data !== wa) begin
      n_err++;
      $display("FAIL ignore_weights_hold: got %h, want %h", arr_weight_data, wa);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    num_vec   = '0;
    weight_in = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    test_reset();
    test_reset_mid_stream();
    test_identity();
    test_back_to_back();
    test_bubbles();
    test_zero();
    test_start_ignored();
    repeat (3) @(negedge clk);
    n_vec++;
    if (sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: %0d results never appeared, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
